core_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single core-side memory request port of the AHB top level between several requesters, such as instruction fetch, load/store and debug.
Each requester presents an addr/wd/we/size/req bundle. The block grants one requester at a time and registers its request onto the downstream port. It holds that request until req_ack, then returns the read data and a one-cycle acknowledge to the granted requester.
It sits between the core-side masters and the AHB top level's core-side inputs.

---
 rtl/core_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_core_req_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_req_arbiter.sv
// Round-robin arbiter sharing one downstream core request port among master_c requesters.
// Optional ARB_TIMEOUT_EN: a transfer without req_ack within timeout_c BUSY cycles completes with m_err=1.
module core_req_arbiter #(
    parameter int master_c  = 2,
    parameter int timeout_c = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [master_c-1:0][31:0] m_addr,
    input  logic [master_c-1:0][31:0] m_wd,
    input  logic [master_c-1:0]       m_we,
    input  logic [master_c-1:0][1:0]  m_size,
    input  logic [master_c-1:0]       m_req,
    output logic [master_c-1:0]       m_req_ack,
    output logic                      m_err,
    output logic [31:0]               m_rd,
    output logic [2:0]                grant_id,
    output logic [31:0]               addr,
    output logic [31:0]               wd,
    output logic                      we,
    output logic [1:0]                size,
    output logic                      req,
    input  logic                      req_ack,
    input  logic [31:0]               rd
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state, state_nx;
    logic [2:0]          last;
    logic [2:0]          winner;
    logic                found;
    logic [3:0]          idx;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wd;
    logic                sel_we;
    logic [1:0]          sel_size;
    logic [master_c-1:0] ack_vec;
    logic                timeout_hit;

    // Scan last+1, last+2, ... modulo master_c; the first requester found wins.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= master_c; i++) begin
            idx = {1'b0, last} + 4'(i);
            if (idx >= 4'(master_c))
                idx = idx - 4'(master_c);
            for (int j = 0; j < master_c; j++) begin
                if (!found && m_req[j] && (idx == 4'(j))) begin
                    found  = 1'b1;
                    winner = 3'(j);
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_wd   = '0;
        sel_we   = 1'b0;
        sel_size = '0;
        ack_vec  = '0;
        for (int j = 0; j < master_c; j++) begin
            if (winner == 3'(j)) begin
                sel_addr = m_addr[j];
                sel_wd   = m_wd[j];
                sel_we   = m_we[j];
                sel_size = m_size[j];
            end
            ack_vec[j] = (grant_id == 3'(j));
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int cnt_w = $clog2(timeout_c + 1);
    logic [cnt_w-1:0] cnt;

    // Counts completed BUSY cycles; held at zero outside BUSY so it is clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state != BUSY)
            cnt <= '0;
        else if (!req_ack)
            cnt <= cnt + cnt_w'(1);
    end

    assign timeout_hit = (state == BUSY) && (cnt == cnt_w'(timeout_c - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = BUSY;
            BUSY:    if (req_ack || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Downstream request and requester response registers; req_ack outside BUSY is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            wd        <= '0;
            we        <= 1'b0;
            size      <= '0;
            req       <= 1'b0;
            m_rd      <= '0;
            m_req_ack <= '0;
            m_err     <= 1'b0;
            grant_id  <= '0;
            last      <= 3'(master_c - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        addr     <= sel_addr;
                        wd       <= sel_wd;
                        we       <= sel_we;
                        size     <= sel_size;
                        grant_id <= winner;
                        last     <= winner;
                        req      <= 1'b1;
                    end
                end
                BUSY: begin
                    if (req_ack) begin
                        m_rd      <= rd;
                        req       <= 1'b0;
                        m_req_ack <= ack_vec;
                        m_err     <= 1'b0;
                    end else if (timeout_hit) begin
                        m_rd      <= '0;
                        req       <= 1'b0;
                        m_req_ack <= ack_vec;
                        m_err     <= 1'b1;
                    end
                end
                RESP: begin
                    m_req_ack <= '0;
                    m_err     <= 1'b0;
                end
                default: begin
                    req       <= 1'b0;
                    m_req_ack <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_req_arbiter.sv
// Bench for core_req_arbiter: constant vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_core_req_arbiter;

    localparam int N = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int tmo_c  = 4;
    localparam int hold_c = 3;
`else
    localparam int tmo_c  = 255;
    localparam int hold_c = 6;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0][31:0] m_addr;
    logic [N-1:0][31:0] m_wd;
    logic [N-1:0]       m_we;
    logic [N-1:0][1:0]  m_size;
    logic [N-1:0]       m_req;
    logic [N-1:0]       m_req_ack;
    logic               m_err;
    logic [31:0]        m_rd;
    logic [2:0]         grant_id;
    logic [31:0]        addr;
    logic [31:0]        wd;
    logic               we;
    logic [1:0]         size;
    logic               req;
    logic               req_ack;
    logic [31:0]        rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_req_arbiter #(.master_c(N), .timeout_c(tmo_c)) dut (
        .clk(clk), .reset(reset),
        .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_size(m_size), .m_req(m_req),
        .m_req_ack(m_req_ack), .m_err(m_err), .m_rd(m_rd), .grant_id(grant_id),
        .addr(addr), .wd(wd), .we(we), .size(size), .req(req),
        .req_ack(req_ack), .rd(rd)
    );

    typedef struct {
        logic [1:0]  mreq;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        ack;
        logic [31:0] rdv;
        logic        ereq;
        logic [31:0] eaddr;
        logic [1:0]  emack;
        logic [31:0] emrd;
        logic [2:0]  egid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] mreq, input logic [31:0] a0, input logic [31:0] a1,
                                input logic ack, input logic [31:0] rdv, input logic ereq,
                                input logic [31:0] eaddr, input logic [1:0] emack,
                                input logic [31:0] emrd, input logic [2:0] egid);
        vec_t v;
        v.mreq = mreq; v.a0 = a0; v.a1 = a1; v.ack = ack; v.rdv = rdv;
        v.ereq = ereq; v.eaddr = eaddr; v.emack = emack; v.emrd = emrd; v.egid = egid;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] short_bundle();
        return 128'({req, addr, m_req_ack, m_rd, grant_id, m_err});
    endfunction

    function automatic logic [127:0] full_bundle();
        return 128'({req, addr, wd, we, size, m_req_ack, m_rd, grant_id, m_err});
    endfunction

    // reference model state (transaction level)
    logic        e_req;
    logic [31:0] e_addr, e_wd, e_mrd;
    logic        e_we;
    logic [1:0]  e_size;
    logic [N-1:0] e_mack;
    int          e_gid;
    int          mlast;

    task automatic model_reset();
        e_req = 1'b0; e_addr = '0; e_wd = '0; e_we = 1'b0; e_size = '0;
        e_mack = '0; e_mrd = '0; e_gid = 0; mlast = N - 1;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        int w;
        if (e_mack != '0) begin
            e_mack = '0;
        end else if (e_req) begin
            if (req_ack) begin
                e_req = 1'b0;
                e_mack = '0;
                e_mack[e_gid] = 1'b1;
                e_mrd = rd;
            end
        end else if (m_req != '0) begin
            w = 0;
            for (int k = 1; k <= N; k++) begin
                w = (mlast + k) % N;
                if (m_req[w]) break;
            end
            e_gid = w; mlast = w; e_req = 1'b1;
            e_addr = m_addr[w]; e_wd = m_wd[w]; e_we = m_we[w]; e_size = m_size[w];
        end
    endtask

    initial begin
        logic [N-1:0] active;
        int           wcnt;

        reset = 1'b1; m_addr = '0; m_wd = '0; m_we = '0; m_size = '0; m_req = '0;
        req_ack = 1'b0; rd = '0;
        tick();
        check("reset_state", full_bundle(), 128'd0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_reset", full_bundle(), 128'd0);

        // alternating grants, ignored acks, then a single requester-0 read
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b0, 32'h0,       1'b1, 32'h100, 2'b00, 32'h0,       3'd0));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b1, 32'h1111,    1'b0, 32'h100, 2'b01, 32'h1111,    3'd0));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b0, 32'h0,       1'b0, 32'h100, 2'b00, 32'h1111,    3'd0));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b0, 32'h0,       1'b1, 32'h200, 2'b00, 32'h1111,    3'd1));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b1, 32'h2222,    1'b0, 32'h200, 2'b10, 32'h2222,    3'd1));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b0, 32'h0,       1'b0, 32'h200, 2'b00, 32'h2222,    3'd1));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b0, 32'h0,       1'b1, 32'h100, 2'b00, 32'h2222,    3'd0));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b1, 32'h3333,    1'b0, 32'h100, 2'b01, 32'h3333,    3'd0));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b0, 32'h0,       1'b0, 32'h100, 2'b00, 32'h3333,    3'd0));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b0, 32'h0,       1'b1, 32'h200, 2'b00, 32'h3333,    3'd1));
        tbl.push_back(mk(2'b11, 32'h100, 32'h200, 1'b1, 32'h4444,    1'b0, 32'h200, 2'b10, 32'h4444,    3'd1));
        tbl.push_back(mk(2'b00, 32'h100, 32'h200, 1'b1, 32'hBAD,     1'b0, 32'h200, 2'b00, 32'h4444,    3'd1));
        tbl.push_back(mk(2'b00, 32'h100, 32'h200, 1'b1, 32'hBAD,     1'b0, 32'h200, 2'b00, 32'h4444,    3'd1));
        tbl.push_back(mk(2'b01, 32'h10,  32'h200, 1'b0, 32'h0,       1'b1, 32'h10,  2'b00, 32'h4444,    3'd0));
        tbl.push_back(mk(2'b01, 32'h10,  32'h200, 1'b0, 32'h0,       1'b1, 32'h10,  2'b00, 32'h4444,    3'd0));
        tbl.push_back(mk(2'b01, 32'h10,  32'h200, 1'b1, 32'hDEADBEEF,1'b0, 32'h10,  2'b01, 32'hDEADBEEF,3'd0));
        tbl.push_back(mk(2'b00, 32'h10,  32'h200, 1'b0, 32'h0,       1'b0, 32'h10,  2'b00, 32'hDEADBEEF,3'd0));

        foreach (tbl[i]) begin
            m_req = tbl[i].mreq; m_addr[0] = tbl[i].a0; m_addr[1] = tbl[i].a1;
            req_ack = tbl[i].ack; rd = tbl[i].rdv;
            tick();
            check($sformatf("table_row%0d", i), short_bundle(),
                  128'({tbl[i].ereq, tbl[i].eaddr, tbl[i].emack, tbl[i].emrd, tbl[i].egid, 1'b0}));
        end
        req_ack = 1'b0; m_req = '0;

        // requester 1 write, fields changed and m_req dropped while waiting for req_ack
        m_addr[1] = 32'h300; m_wd[1] = 32'h1234_5678; m_we[1] = 1'b1; m_size[1] = 2'd2;
        m_req = 2'b10;
        tick();
        check("write_grant", 128'({req, addr, wd, we, size, grant_id}),
              128'({1'b1, 32'h300, 32'h1234_5678, 1'b1, 2'd2, 3'd1}));
        m_addr[1] = 32'hFFF0; m_wd[1] = 32'h0; m_we[1] = 1'b0; m_size[1] = 2'd0;
        for (int i = 0; i < hold_c; i++) begin
            if (i >= hold_c / 2) m_req = 2'b00;
            tick();
            check($sformatf("write_hold%0d", i), 128'({req, addr, wd, we, size, m_req_ack}),
                  128'({1'b1, 32'h300, 32'h1234_5678, 1'b1, 2'd2, 2'b00}));
        end
        req_ack = 1'b1; rd = 32'hCAFE_F00D;
        tick();
        check("write_ack", 128'({req, m_req_ack, m_rd, grant_id, m_err}),
              128'({1'b0, 2'b10, 32'hCAFE_F00D, 3'd1, 1'b0}));
        req_ack = 1'b0;
        tick();
        check("write_ack_clear", 128'({req, m_req_ack}), 128'd0);

        // reset while BUSY with requester 0 granted; pointer must be reinitialised
        m_addr[0] = 32'h40; m_addr[1] = 32'h80; m_req = 2'b01;
        tick();
        check("pre_reset_grant", 128'({req, grant_id, addr}), 128'({1'b1, 3'd0, 32'h40}));
        m_req = 2'b11;
        tick();
        #2 reset = 1'b1;
        #1;
        check("reset_async", full_bundle(), 128'd0);
        tick();
        check("reset_held", full_bundle(), 128'd0);
        reset = 1'b0;
        tick();
        check("post_reset_grant", 128'({req, grant_id, addr, m_req_ack}),
              128'({1'b1, 3'd0, 32'h40, 2'b00}));
        req_ack = 1'b1; rd = 32'h5A5A;
        tick();
        check("post_reset_ack", 128'({m_req_ack, m_rd}), 128'({2'b01, 32'h5A5A}));
        req_ack = 1'b0; m_req = '0;
        tick();
        check("post_reset_ack_clear", 128'({req, m_req_ack}), 128'd0);

`ifdef ARB_TIMEOUT_EN
        m_req = 2'b01;
        tick();
        m_req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("tmo_wait%0d", i), 128'({req, m_req_ack}), 128'({1'b1, 2'b00}));
        end
        tick();
        check("tmo_fire", 128'({req, m_req_ack, m_err, m_rd}), 128'({1'b0, 2'b01, 1'b1, 32'h0}));
        tick();
        check("tmo_clear", 128'({m_req_ack, m_err}), 128'd0);
        m_req = 2'b01;
        tick();
        m_req = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        req_ack = 1'b1; rd = 32'h77;
        tick();
        check("tmo_ack_wins", 128'({req, m_req_ack, m_err, m_rd}), 128'({1'b0, 2'b01, 1'b0, 32'h77}));
        req_ack = 1'b0;
        tick();
`endif

        // randomized run against the reference model
        reset = 1'b1; m_req = '0; req_ack = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        active = '0;
        wcnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!active[i] && $urandom_range(0, 3) == 0) begin
                    active[i] = 1'b1;
                    m_addr[i] = $urandom; m_wd[i] = $urandom;
                    m_we[i] = 1'($urandom_range(0, 1)); m_size[i] = 2'($urandom_range(0, 3));
                end
                m_req[i] = active[i];
            end
            wcnt = e_req ? wcnt + 1 : 0;
            req_ack = (wcnt >= 3) || ($urandom_range(0, 2) == 0);
            rd = $urandom;
            model_step();
            tick();
            check($sformatf("random_cyc%0d", cyc), full_bundle(),
                  128'({e_req, e_addr, e_wd, e_we, e_size, e_mack, e_mrd, 3'(e_gid), 1'b0}));
            for (int i = 0; i < N; i++) begin
                if (e_mack[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        active[i] = 1'b0;
                    end else begin
                        m_addr[i] = $urandom; m_wd[i] = $urandom;
                        m_we[i] = 1'($urandom_range(0, 1)); m_size[i] = 2'($urandom_range(0, 3));
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
